alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised, clocked successor to the datapath ALU.
- Adds XOR, shifts, SUB, compares and an iterative unsigned multiply/divide unit behind a valid/ready handshake.
- Sits in the EX stage. Single-cycle ops return after 1 cycle; MUL/DIV ops stall the pipeline through InReady/OutValid.

Parameters:
- DATA_WIDTH, 32: operand and result width (>= 8, power of two).
- OPCODE_LENGTH, 4: Operation field width (fixed encoding below requires 4).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- InValid  input  1  operands/Operation valid.
- InReady  output  1  unit can accept a new operation.
- SrcA  input  DATA_WIDTH  operand A.
- SrcB  input  DATA_WIDTH  operand B.
- Operation  input  OPCODE_LENGTH  operation select.
- OutValid  output  1  ALUResult valid.
- OutReady  input  1  consumer accepts result.
- ALUResult  output  DATA_WIDTH  registered result.
- Zero  output  1  ALUResult == 0, registered with ALUResult.
- Busy  output  1  high while in BUSY state.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
  - reset low at a clk edge forces state IDLE, ALUResult=0, Zero=0, OutValid=0, Busy=0, counter=0.
  - In-flight operations are abandoned, including mid-iteration.
- Encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA.
  - 1000 EQ, 1001 NE, 1010 SLT (signed), 1011 SLTU.
  - 1100 MUL (low half), 1101 MULHU (high half, unsigned), 1110 DIVU, 1111 REMU.
- Shifts: amount = SrcB[$clog2(DATA_WIDTH)-1:0]; upper bits ignored. SRA replicates SrcA MSB.
- Compares: result is 1 or 0, zero-extended to DATA_WIDTH.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no flags besides Zero.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: InReady=1. On InValid:
    - Ops 0000-1011: compute, register result, go to DONE. Latency 1 cycle from accept to OutValid.
    - Ops 1100-1111: latch operands, counter=0, go to BUSY.
  - BUSY: InReady=0, Busy=1.
    - MUL/MULHU: one shift-add step per cycle on a 2*DATA_WIDTH accumulator.
    - DIVU/REMU: one restoring shift-subtract step per cycle.
    - After DATA_WIDTH steps, register result and go to DONE.
    - Total latency DATA_WIDTH+1 cycles from accept to OutValid.
  - DONE: OutValid=1, InReady=0. ALUResult and Zero are held stable until OutReady=1, then go to IDLE.
    - The next operation can be accepted the cycle after the handoff; no same-cycle re-accept.
- Input hold: InValid/operands are sampled only on the accept edge and may change afterwards.
- Divide by zero (SrcB=0), RISC-V semantics:
  - DIVU result = all ones; REMU result = SrcA.
  - Still takes the full DATA_WIDTH iterations, giving a constant latency.
- SrcA=SrcB=0 with MUL gives result 0 and Zero=1.
- OutReady high while not in DONE has no effect.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: opcodes 1100-1111 behave as above.
- Undefined:
  - No multiply/divide datapath or BUSY iteration logic is synthesised.
  - Opcodes 1100-1111 complete in 1 cycle with ALUResult=0, Zero=1, behaving as single-cycle ops.
  - Busy is tied 0.

Test Plan (DATA_WIDTH=32):
- Reset/idle: hold reset=0 for 2 cycles during a DIVU in BUSY, then release → OutValid=0, ALUResult=0, InReady=1 on the first cycle after release.
- ALU ops: ADD 0xFFFFFFFF+1 → 0x00000000, Zero=1, OutValid one cycle after accept. SUB 5-7 → 0xFFFFFFFE. SRA 0x80000000 by SrcB=0x24 (amount 4) → 0xF8000000. SLT -1<1 → 1. SLTU 0xFFFFFFFF<1 → 0.
- Multiply: MUL 0x10000×0x10000 → 0x00000000 with Zero=1. MULHU same operands → 0x00000001. OutValid exactly 33 cycles after accept; Busy high for 32 cycles.
- Divide: DIVU 100/7 → 14, REMU 100/7 → 2. DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, both with 33-cycle latency.
- Backpressure: hold OutReady=0 for 10 cycles in DONE while driving new InValid/operands → ALUResult stable, InReady=0, new op not accepted. Drop OutReady to 1 → IDLE next cycle, new op accepted the cycle after.
- Feature off (ALU_MULDIV_EN undefined): MUL 3×4 → ALUResult=0, Zero=1, OutValid after 1 cycle, Busy never asserted.

Source files
------------

// File: rtl/alu_multicycle.sv
// Clocked EX-stage ALU: single-cycle logic/arith/shift/compare ops plus an iterative
// unsigned MUL/MULHU/DIVU/REMU unit enabled by the ALU_MULDIV_EN macro.
module alu_multicycle #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     Zero,
    output logic                     Busy
);
    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    zero_q;
    logic [DATA_WIDTH-1:0]   alu_d;
    logic [SHW-1:0]          shamt;

    always_comb begin
        shamt = SrcB[SHW-1:0];
        alu_d = '0;
        case (Operation)
            4'b0000: alu_d = SrcA & SrcB;
            4'b0001: alu_d = SrcA | SrcB;
            4'b0010: alu_d = SrcA + SrcB;
            4'b0011: alu_d = SrcA ^ SrcB;
            4'b0100: alu_d = SrcA << shamt;
            4'b0101: alu_d = SrcA >> shamt;
            4'b0110: alu_d = SrcA - SrcB;
            4'b0111: alu_d = DATA_WIDTH'($signed(SrcA) >>> shamt);
            4'b1000: alu_d = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
            4'b1001: alu_d = {{(DATA_WIDTH-1){1'b0}}, SrcA != SrcB};
            4'b1010: alu_d = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            4'b1011: alu_d = {{(DATA_WIDTH-1){1'b0}}, SrcA < SrcB};
            default: alu_d = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // acc_q: MUL = {partial product, remaining multiplier}; DIV = {remainder, dividend/quotient}
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [2*DATA_WIDTH-1:0] acc_d;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [1:0]              op_q;
    logic [SHW:0]            cnt_q;
    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH:0]     div_sh;
    logic [DATA_WIDTH:0]     div_diff;
    logic [DATA_WIDTH-1:0]   md_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                 + (acc_q[0] ? {1'b0, b_q} : '0);
        div_sh   = acc_q[2*DATA_WIDTH-1:DATA_WIDTH-1];
        div_diff = div_sh - {1'b0, b_q};
        acc_d    = '0;
        if (op_q[1]) begin
            if (div_sh >= {1'b0, b_q})
                acc_d = {div_diff[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};
            else
                acc_d = {div_sh[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[DATA_WIDTH-1:1]};
        end
        // Upper half holds MULHU product / REMU remainder, lower half MUL product / DIVU quotient
        md_res = op_q[0] ? acc_d[2*DATA_WIDTH-1:DATA_WIDTH] : acc_d[DATA_WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (InValid) begin
`ifdef ALU_MULDIV_EN
                        if (Operation[3:2] == 2'b11) begin
                            acc_q   <= {{DATA_WIDTH{1'b0}}, SrcA};
                            b_q     <= SrcB;
                            op_q    <= Operation[1:0];
                            cnt_q   <= '0;
                            state_q <= BUSY;
                        end else
`endif
                        begin
                            result_q <= alu_d;
                            zero_q   <= (alu_d == '0);
                            state_q  <= DONE;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == (SHW+1)'(DATA_WIDTH-1)) begin
                        result_q <= md_res;
                        zero_q   <= (md_res == '0);
                        state_q  <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (OutReady) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign InReady   = (state_q == IDLE);
    assign OutValid  = (state_q == DONE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;
`ifdef ALU_MULDIV_EN
    assign Busy      = (state_q == BUSY);
`else
    assign Busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle (DATA_WIDTH=32); expectations follow ALU_MULDIV_EN.
module tb_alu_multicycle;
    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int MD_LAT = MD ? W + 1 : 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         InValid;
    logic         InReady;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic [3:0]   Operation;
    logic         OutValid;
    logic         OutReady;
    logic [W-1:0] ALUResult;
    logic         Zero;
    logic         Busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .OutValid(OutValid),
        .OutReady(OutReady), .ALUResult(ALUResult), .Zero(Zero), .Busy(Busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int bsy;
        @(negedge clk);
        chk({tag, ".inready"}, 32'(InReady), 32'd1);
        InValid = 1'b1; Operation = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        InValid = 1'b0; SrcA = $urandom; SrcB = $urandom; Operation = ~op;
        lat = 1; bsy = 0;
        while (!OutValid && lat < 200) begin
            if (Busy) bsy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"},    32'(lat), 32'(exp_lat));
        chk({tag, ".busy"},   32'(bsy), 32'(exp_lat - 1));
        chk({tag, ".result"}, ALUResult, exp);
        chk({tag, ".zero"},   32'(Zero), 32'(exp == 32'd0));
        @(negedge clk); OutReady = 1'b1;
        @(posedge clk); #1; OutReady = 1'b0;
        chk({tag, ".handoff"}, {30'd0, OutValid, InReady}, 32'b01);
    endtask

    initial begin
        reset = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        SrcA = '0; SrcB = '0; Operation = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.outvalid", 32'(OutValid), 32'd0);
        chk("rst.result",   ALUResult,     32'd0);
        chk("rst.zero",     32'(Zero),     32'd0);
        chk("rst.inready",  32'(InReady),  32'd1);
        chk("rst.busy",     32'(Busy),     32'd0);
        @(negedge clk); reset = 1'b1;

        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1);
        run_op("sub",      4'b0110, 32'd5,         32'd7,         32'hFFFF_FFFE, 1);
        run_op("sra",      4'b0111, 32'h8000_0000, 32'h24,        32'hF800_0000, 1);
        run_op("slt",      4'b1010, 32'hFFFF_FFFF, 32'h1,         32'h1,         1);
        run_op("sltu",     4'b1011, 32'hFFFF_FFFF, 32'h1,         32'h0,         1);
        run_op("and",      4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1);
        run_op("or",       4'b0001, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1);
        run_op("xor",      4'b0011, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1);
        run_op("sll",      4'b0100, 32'h1,         32'h1F,        32'h8000_0000, 1);
        run_op("srl",      4'b0101, 32'h8000_0000, 32'h21,        32'h4000_0000, 1);
        run_op("eq",       4'b1000, 32'd7,         32'd7,         32'h1,         1);
        run_op("ne",       4'b1001, 32'd7,         32'd7,         32'h0,         1);

        run_op("mul_ovf",   4'b1100, 32'h1_0000,     32'h1_0000,     32'h0,                      MD_LAT);
        run_op("mulhu",     4'b1101, 32'h1_0000,     32'h1_0000,     MD ? 32'h1 : 32'h0,         MD_LAT);
        run_op("mul_3x4",   4'b1100, 32'd3,          32'd4,          MD ? 32'd12 : 32'h0,        MD_LAT);
        run_op("mul_zero",  4'b1100, 32'd0,          32'd0,          32'h0,                      MD_LAT);
        run_op("mulhu_max", 4'b1101, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  MD ? 32'hFFFF_FFFE : 32'h0, MD_LAT);
        run_op("mul_max",   4'b1100, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  MD ? 32'h1 : 32'h0,         MD_LAT);
        run_op("divu",      4'b1110, 32'd100,        32'd7,          MD ? 32'd14 : 32'h0,        MD_LAT);
        run_op("remu",      4'b1111, 32'd100,        32'd7,          MD ? 32'd2 : 32'h0,         MD_LAT);
        run_op("divu_z",    4'b1110, 32'd5,          32'd0,          MD ? 32'hFFFF_FFFF : 32'h0, MD_LAT);
        run_op("remu_z",    4'b1111, 32'd5,          32'd0,          MD ? 32'd5 : 32'h0,         MD_LAT);
        run_op("divu_max",  4'b1110, 32'hFFFF_FFFF,  32'd1,          MD ? 32'hFFFF_FFFF : 32'h0, MD_LAT);

        // Backpressure: hold result in DONE while a new request is presented
        @(negedge clk);
        InValid = 1'b1; Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd2;
        @(posedge clk); #1;
        SrcA = 32'd10; SrcB = 32'd20;
        for (int i = 0; i < 10; i++) begin
            chk("bp.result",   ALUResult,        32'd3);
            chk("bp.inready",  32'(InReady),     32'd0);
            chk("bp.outvalid", 32'(OutValid),    32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk); OutReady = 1'b1;
        @(posedge clk); #1;
        chk("bp.handoff_inready",  32'(InReady),  32'd1);
        chk("bp.handoff_outvalid", 32'(OutValid), 32'd0);
        @(negedge clk); OutReady = 1'b0;
        @(posedge clk); #1;
        InValid = 1'b0;
        chk("bp.next_outvalid", 32'(OutValid), 32'd1);
        chk("bp.next_result",   ALUResult,     32'd30);
        @(negedge clk); OutReady = 1'b1;
        @(posedge clk); #1; OutReady = 1'b0;

        // Reset in the middle of a DIVU iteration
        @(negedge clk);
        InValid = 1'b1; Operation = 4'b1110; SrcA = 32'd100; SrcB = 32'd7;
        @(posedge clk); #1;
        InValid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid.busy", 32'(Busy), 32'(MD));
        @(negedge clk); reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid.rst_busy", 32'(Busy), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("mid.outvalid", 32'(OutValid), 32'd0);
        chk("mid.result",   ALUResult,     32'd0);
        chk("mid.inready",  32'(InReady),  32'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("mid.no_resume", 32'(OutValid), 32'd0);

        run_op("after_rst", 4'b0010, 32'd40, 32'd2, 32'd42, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
